// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline stage register carrying a data bundle and a
// control bundle with a valid/ready handshake, synchronous flush with bubble
// insertion, and saturating stall/bubble performance counters.
// Optional build macro PIPE_SKID_EN adds a one-entry skid buffer so that
// in_ready becomes a registered signal with no path from out_ready.
// Whenever out_valid is low, out_ctrl is forced to CTRL_BUBBLE so that the
// downstream stage never sees live write enables from an empty stage.
module pipe_stage_reg #(
  parameter int                DATA_W      = 128,
  parameter int                CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic in_xfer;
  logic main_free;

  // The main entry can take a new beat when empty or being drained this cycle.
  assign main_free = !valid_q || out_ready;
  assign in_xfer   = in_valid && in_ready;

`ifdef PIPE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  // Registered ready: the stage only refuses input once the skid entry is full.
  assign in_ready = !skid_valid_q;

  // Next state for main and skid entries; skid drains into main before new input.
  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    ctrl_d       = ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    if (flush) begin
      valid_d      = 1'b0;
      ctrl_d       = CTRL_BUBBLE;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        valid_d      = 1'b1;
        data_d       = skid_data_q;
        ctrl_d       = skid_ctrl_q;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        valid_d = 1'b1;
        data_d  = in_data;
        ctrl_d  = in_ctrl;
      end else begin
        valid_d = 1'b0;
        ctrl_d  = CTRL_BUBBLE;
      end
    end else if (in_xfer) begin
      // Main is stalled: park the accepted beat behind it to preserve order.
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
      skid_ctrl_d  = in_ctrl;
    end
  end

  // Skid entry storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= CTRL_BUBBLE;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
    end
  end
`else
  // Single entry: accept whenever the held beat leaves (or there is none).
  assign in_ready = main_free;

  // Next state for the single entry; flush wins, then load, then drain to bubble.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_BUBBLE;
    end else if (in_xfer) begin
      valid_d = 1'b1;
      data_d  = in_data;
      ctrl_d  = in_ctrl;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_BUBBLE;
    end
  end
`endif

  // Saturating counters judge the current (pre-flush) state; flush never clears them.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (!valid_q && out_ready && (bubble_cnt_q != {CNT_W{1'b1}}))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  // Main entry and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      ctrl_q       <= CTRL_BUBBLE;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      ctrl_q       <= ctrl_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_ctrl   = ctrl_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed stimulus, queue-based reference model,
// per-cycle compare on the falling edge plus literal expectations.
module tb_pipe_stage_reg;
  localparam int             DW = 128;
  localparam int             CW = 16;
  localparam logic [CW-1:0]  CB = 16'h0000;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;

  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [15:0]   stall_cnt, bubble_cnt;

  logic          in_ready4, out_valid4;
  logic [DW-1:0] out_data4;
  logic [CW-1:0] out_ctrl4;
  logic [3:0]    stall_cnt4, bubble_cnt4;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(CB), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(CB), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_ctrl(out_ctrl4), .stall_cnt(stall_cnt4), .bubble_cnt(bubble_cnt4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  // Reference model: the stage's contents as an ordered queue of beats.
  beat_t mq[$];
  int m_stall = 0, m_bubble = 0, m_stall4 = 0, m_bubble4 = 0;

  function automatic bit m_in_ready();
    if (SKID) return mq.size() < 2;
    return (mq.size() == 0) || out_ready;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_stall = 0; m_bubble = 0; m_stall4 = 0; m_bubble4 = 0;
  endtask

  // Advance one clock: evaluate the model from pre-edge state and inputs.
  task automatic tick();
    bit inx, outx, st, bu;
    beat_t b;
    inx  = in_valid && m_in_ready();
    outx = (mq.size() > 0) && out_ready;
    st   = (mq.size() > 0) && !out_ready;
    bu   = (mq.size() == 0) && out_ready;
    b.d  = in_data;
    b.c  = in_ctrl;
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      if (st && m_stall < 65535) m_stall++;
      if (bu && m_bubble < 65535) m_bubble++;
      if (st && m_stall4 < 15) m_stall4++;
      if (bu && m_bubble4 < 15) m_bubble4++;
      if (flush) mq.delete();
      else begin
        if (outx) void'(mq.pop_front());
        if (inx) mq.push_back(b);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0; in_ctrl = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    model_clear();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_beat(input int v);
    in_valid = 1'b1;
    in_data  = DW'(v);
    in_ctrl  = 16'h8000 | 16'(v & 32'h7fff);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("out_valid", out_valid, mq.size() > 0);
    chk("out_ctrl", out_ctrl, (mq.size() > 0) ? mq[0].c : CB);
    if (mq.size() > 0) chk("out_data", out_data, mq[0].d);
    chk("in_ready", in_ready, m_in_ready());
    chk("stall_cnt", stall_cnt, m_stall);
    chk("bubble_cnt", bubble_cnt, m_bubble);
    chk("stall_cnt4", stall_cnt4, m_stall4);
    chk("bubble_cnt4", bubble_cnt4, m_bubble4);
    chk("out_valid4", out_valid4, out_valid);
  end

  initial begin
    #1;
    tick();
    do_reset();

    // 1: reset mid-traffic with five stall cycles accumulated
    set_beat(7);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t1_stall5", stall_cnt, 16'd5);
    chk("t1_valid_pre", out_valid, 1'b1);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    chk("t1_valid_rst", out_valid, 1'b0);
    chk("t1_ctrl_rst", out_ctrl, CB);
    chk("t1_data_rst", out_data, '0);
    chk("t1_stall_rst", stall_cnt, 16'd0);
    tick();
    reset = 1'b0;

    // 2: continuous stream with downstream always ready
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      set_beat(i);
      tick();
      chk("t2_stream_data", out_data, DW'(i));
    end
    chk("t2_bubble1", bubble_cnt, 16'd1);
    chk("t2_stall0", stall_cnt, 16'd0);
    in_valid = 1'b0;
    tick();

    // 3: three-cycle stall holding 0xA, next beat 0xB waiting upstream
    do_reset();
    set_beat(32'hA);
    tick();
    set_beat(32'hB);
    for (int i = 0; i < 3; i++) tick();
    chk("t3_hold", out_data, DW'(32'hA));
    chk("t3_stall3", stall_cnt, 16'd3);
    chk("t3_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t3_next_B", out_data, DW'(32'hB));
    tick();
    chk("t3_drained", out_valid, 1'b0);

    // 4: flush during stall with a new beat offered
    do_reset();
    set_beat(32'hA);
    tick();
    flush = 1'b1;
    set_beat(32'hC);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t4_valid", out_valid, 1'b0);
    chk("t4_ctrl", out_ctrl, CB);
    chk("t4_stall_kept", stall_cnt, 16'd1);
    tick();
    chk("t4_not_captured", out_valid, 1'b0);
    chk("t4_stall_same", stall_cnt, 16'd1);

    // 5: 20-cycle stall saturates the 4-bit counter
    do_reset();
    set_beat(32'h55);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("t5_sat4", stall_cnt4, 4'd15);
    chk("t5_cnt16", stall_cnt, 16'd20);

`ifdef PIPE_SKID_EN
    // 6: skid holds the second beat while stalled, then releases in order
    do_reset();
    set_beat(1);
    tick();
    set_beat(2);
    tick();
    set_beat(3);
    chk("t6_in_ready0", in_ready, 1'b0);
    chk("t6_main1", out_data, DW'(1));
    tick();
    chk("t6_still1", out_data, DW'(1));
    out_ready = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("t6_then2", out_data, DW'(2));
    chk("t6_valid2", out_valid, 1'b1);
    tick();
    chk("t6_empty", out_valid, 1'b0);
`endif

    // Mixed traffic pattern with occasional flushes, checked by the model
    do_reset();
    for (int i = 0; i < 48; i++) begin
      if (i % 3 != 0) set_beat(100 + i);
      else in_valid = 1'b0;
      out_ready = (i % 4 != 1);
      flush = (i == 17) || (i == 33);
      tick();
    end
    idle_inputs();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
